// File: rtl/rv32i_decode_exec.sv
// RV32I decode/execute slice: decoder, register file, main control, ALU and pc+imm adder.
// Everything is combinational except the register file writes.
module rv32i_decode_exec #(
    parameter int ISA_WIDTH = 32,
    parameter int GPR_NUM   = 32
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [ISA_WIDTH-1:0] inst,
    input  logic [ISA_WIDTH-1:0] pc,
    input  logic [ISA_WIDTH-1:0] srd,
    output logic [2:0]           inst_type,
    output logic [ISA_WIDTH-1:0] imm,
    output logic [6:0]           opcode,
    output logic [2:0]           funct3,
    output logic [6:0]           funct7,
    output logic [ISA_WIDTH-1:0] src1,
    output logic [ISA_WIDTH-1:0] src2,
    output logic [ISA_WIDTH-1:0] alu_result,
    output logic [ISA_WIDTH-1:0] pc_imm,
    output logic                 gpr_w_en,
    output logic                 pc_en,
    output logic                 mem_if_en,
    output logic                 is_branch,
    output logic                 is_jal,
    output logic                 is_jalr,
    output logic                 mem_r_en,
    output logic                 mem_w_en,
    output logic [3:0]           mem_mask,
    output logic                 rd_is_mem,
    output logic                 is_lui,
    output logic                 is_auipc
);

    localparam logic [6:0] OP_R     = 7'b0110011;
    localparam logic [6:0] OP_IMM   = 7'b0010011;
    localparam logic [6:0] OP_LOAD  = 7'b0000011;
    localparam logic [6:0] OP_JALR  = 7'b1100111;
    localparam logic [6:0] OP_STORE = 7'b0100011;
    localparam logic [6:0] OP_BR    = 7'b1100011;
    localparam logic [6:0] OP_LUI   = 7'b0110111;
    localparam logic [6:0] OP_AUIPC = 7'b0010111;
    localparam logic [6:0] OP_JAL   = 7'b1101111;

    localparam logic [2:0] T_R   = 3'd0;
    localparam logic [2:0] T_I   = 3'd1;
    localparam logic [2:0] T_S   = 3'd2;
    localparam logic [2:0] T_B   = 3'd3;
    localparam logic [2:0] T_U   = 3'd4;
    localparam logic [2:0] T_J   = 3'd5;
    localparam logic [2:0] T_INV = 3'd7;

    logic [4:0] rs1, rs2, rd;
    logic       op_r, op_imm, op_load, op_store, op_br;
    logic [ISA_WIDTH-1:0] op_b;
    logic [4:0] shamt;
    logic [ISA_WIDTH-1:0] gpr [GPR_NUM];

    assign opcode = inst[6:0];
    assign funct3 = inst[14:12];
    assign funct7 = inst[31:25];
    assign rd     = inst[11:7];
    assign rs1    = inst[19:15];
    assign rs2    = inst[24:20];

    assign op_r     = (opcode == OP_R);
    assign op_imm   = (opcode == OP_IMM);
    assign op_load  = (opcode == OP_LOAD);
    assign op_store = (opcode == OP_STORE);
    assign op_br    = (opcode == OP_BR);
    assign is_jalr  = (opcode == OP_JALR);
    assign is_lui   = (opcode == OP_LUI);
    assign is_auipc = (opcode == OP_AUIPC);
    assign is_jal   = (opcode == OP_JAL);

    always_comb begin
        inst_type = T_INV;
        imm       = '0;
        case (opcode)
            OP_R: inst_type = T_R;
            OP_IMM, OP_LOAD, OP_JALR: begin
                inst_type = T_I;
                imm       = {{20{inst[31]}}, inst[31:20]};
            end
            OP_STORE: begin
                inst_type = T_S;
                imm       = {{20{inst[31]}}, inst[31:25], inst[11:7]};
            end
            OP_BR: begin
                inst_type = T_B;
                imm       = {{19{inst[31]}}, inst[31], inst[7], inst[30:25], inst[11:8], 1'b0};
            end
            OP_LUI, OP_AUIPC: begin
                inst_type = T_U;
                imm       = {inst[31:12], 12'b0};
            end
            OP_JAL: begin
                inst_type = T_J;
                imm       = {{11{inst[31]}}, inst[31], inst[19:12], inst[20], inst[30:21], 1'b0};
            end
            default: ;
        endcase
    end

    // Old value on same-cycle read of the written register: no write-to-read bypass.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int unsigned i = 0; i < GPR_NUM; i++) gpr[i] <= '0;
        end else if (gpr_w_en && rd != 5'd0) begin
            gpr[rd] <= srd;
        end
    end

    assign src1 = (rs1 == 5'd0) ? '0 : gpr[rs1];
    assign src2 = (rs2 == 5'd0) ? '0 : gpr[rs2];

    assign gpr_w_en  = op_r | op_imm | op_load | is_jalr | is_lui | is_auipc | is_jal;
    assign mem_r_en  = op_load;
    assign mem_w_en  = op_store;
    assign rd_is_mem = op_load;
    assign pc_en     = rst;
    assign mem_if_en = rst;
    assign pc_imm    = pc + imm;

    assign op_b  = (op_imm | op_load | op_store | is_jalr) ? imm : src2;
    assign shamt = op_b[4:0];

    always_comb begin
        alu_result = src1 + op_b;
        if (op_r || op_imm) begin
            case (funct3)
                3'b000: alu_result = (op_r && inst[30]) ? src1 - op_b : src1 + op_b;
                3'b001: alu_result = src1 << shamt;
                3'b010: alu_result = {{(ISA_WIDTH-1){1'b0}}, $signed(src1) < $signed(op_b)};
                3'b011: alu_result = {{(ISA_WIDTH-1){1'b0}}, src1 < op_b};
                3'b100: alu_result = src1 ^ op_b;
                3'b101: alu_result = inst[30] ? ISA_WIDTH'($signed(src1) >>> shamt) : src1 >> shamt;
                3'b110: alu_result = src1 | op_b;
                default: alu_result = src1 & op_b;
            endcase
        end else if (op_br) begin
            alu_result = '0;
            case (funct3)
                3'b000: alu_result[0] = (src1 == op_b);
                3'b001: alu_result[0] = (src1 != op_b);
                3'b100: alu_result[0] = $signed(src1) < $signed(op_b);
                3'b101: alu_result[0] = $signed(src1) >= $signed(op_b);
                3'b110: alu_result[0] = src1 < op_b;
                3'b111: alu_result[0] = src1 >= op_b;
                default: ;
            endcase
        end
    end

    assign is_branch = op_br & alu_result[0];

    always_comb begin
        mem_mask = 4'b0000;
        if (op_load || op_store) begin
            case (funct3[1:0])
                2'b00: mem_mask = 4'b0001;
                2'b01: mem_mask = 4'b0011;
                2'b10: mem_mask = 4'b1111;
                default: mem_mask = 4'b0000;
            endcase
        end
    end

endmodule

// File: tb/tb_rv32i_decode_exec.sv
// Bench for rv32i_decode_exec: directed scenarios plus randomized instructions
// checked against an instruction-level reference model with its own register array.
module tb_rv32i_decode_exec;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [31:0] inst = '0, pc = '0, srd = '0;
    logic [2:0]  inst_type;
    logic [31:0] imm, src1, src2, alu_result, pc_imm;
    logic [6:0]  opcode, funct7;
    logic [2:0]  funct3;
    logic        gpr_w_en, pc_en, mem_if_en, is_branch, is_jal, is_jalr;
    logic        mem_r_en, mem_w_en, rd_is_mem, is_lui, is_auipc;
    logic [3:0]  mem_mask;

    int n_cmp = 0;
    int n_err = 0;
    logic [31:0] mregs [32];

    typedef struct packed {
        logic [2:0]  inst_type;
        logic [31:0] imm;
        logic [6:0]  opcode;
        logic [2:0]  funct3;
        logic [6:0]  funct7;
        logic [31:0] src1;
        logic [31:0] src2;
        logic [31:0] alu_result;
        logic [31:0] pc_imm;
        logic        gpr_w_en, pc_en, mem_if_en, is_branch, is_jal, is_jalr;
        logic        mem_r_en, mem_w_en;
        logic [3:0]  mem_mask;
        logic        rd_is_mem, is_lui, is_auipc;
    } exp_t;

    rv32i_decode_exec #(.ISA_WIDTH(32), .GPR_NUM(32)) dut (
        .clk(clk), .rst(rst), .inst(inst), .pc(pc), .srd(srd),
        .inst_type(inst_type), .imm(imm), .opcode(opcode), .funct3(funct3), .funct7(funct7),
        .src1(src1), .src2(src2), .alu_result(alu_result), .pc_imm(pc_imm),
        .gpr_w_en(gpr_w_en), .pc_en(pc_en), .mem_if_en(mem_if_en), .is_branch(is_branch),
        .is_jal(is_jal), .is_jalr(is_jalr), .mem_r_en(mem_r_en), .mem_w_en(mem_w_en),
        .mem_mask(mem_mask), .rd_is_mem(rd_is_mem), .is_lui(is_lui), .is_auipc(is_auipc)
    );

    always #5 clk = ~clk;

    // Instruction-level model: what an RV32I hart computes for this instruction.
    function automatic exp_t model(input logic [31:0] in, input logic [31:0] p, input logic [31:0] a, input logic [31:0] b);
        exp_t e;
        logic [6:0] op;
        logic [2:0] f3;
        logic [31:0] opb;
        int unsigned sh;
        logic is_r, is_i, is_ld, is_jr, is_st, is_br, is_u1, is_u2, is_j;
        e = '0;
        op = in[6:0];
        f3 = in[14:12];
        e.opcode = op; e.funct3 = f3; e.funct7 = in[31:25];
        e.src1 = a; e.src2 = b;
        e.pc_en = 1'b1; e.mem_if_en = 1'b1;
        is_r = (op == 7'h33); is_i = (op == 7'h13); is_ld = (op == 7'h03); is_jr = (op == 7'h67);
        is_st = (op == 7'h23); is_br = (op == 7'h63); is_u1 = (op == 7'h37); is_u2 = (op == 7'h17);
        is_j = (op == 7'h6F);
        if (is_r) e.inst_type = 3'd0;
        else if (is_i || is_ld || is_jr) begin
            e.inst_type = 3'd1; e.imm = 32'($signed(in) >>> 20);
        end else if (is_st) begin
            e.inst_type = 3'd2; e.imm = 32'(($signed(in) >>> 25) * 32) + 32'(in[11:7]);
        end else if (is_br) begin
            e.inst_type = 3'd3;
            e.imm = (in[31] ? 32'hFFFFF000 : 32'h0) + (32'(in[7]) << 11) + (32'(in[30:25]) << 5) + (32'(in[11:8]) << 1);
        end else if (is_u1 || is_u2) begin
            e.inst_type = 3'd4; e.imm = (in >> 12) << 12;
        end else if (is_j) begin
            e.inst_type = 3'd5;
            e.imm = (in[31] ? 32'hFFF00000 : 32'h0) + (32'(in[19:12]) << 12) + (32'(in[20]) << 11) + (32'(in[30:21]) << 1);
        end else e.inst_type = 3'd7;
        e.pc_imm = p + e.imm;
        opb = (is_i || is_ld || is_st || is_jr) ? e.imm : b;
        sh = opb % 32;
        if (is_r || is_i) begin
            case (f3)
                3'd0: e.alu_result = (is_r && in[30]) ? a - opb : a + opb;
                3'd1: e.alu_result = a << sh;
                3'd2: e.alu_result = ($signed(a) < $signed(opb)) ? 32'd1 : 32'd0;
                3'd3: e.alu_result = (a < opb) ? 32'd1 : 32'd0;
                3'd4: e.alu_result = a ^ opb;
                3'd5: e.alu_result = in[30] ? 32'($signed(a) >>> sh) : a >> sh;
                3'd6: e.alu_result = a | opb;
                default: e.alu_result = a & opb;
            endcase
        end else if (is_br) begin
            case (f3)
                3'd0: e.alu_result = 32'(a == b);
                3'd1: e.alu_result = 32'(a != b);
                3'd4: e.alu_result = 32'($signed(a) < $signed(b));
                3'd5: e.alu_result = 32'($signed(a) >= $signed(b));
                3'd6: e.alu_result = 32'(a < b);
                3'd7: e.alu_result = 32'(a >= b);
                default: e.alu_result = 32'd0;
            endcase
            e.is_branch = (e.alu_result == 32'd1);
        end else e.alu_result = a + opb;
        e.gpr_w_en = is_r | is_i | is_ld | is_jr | is_u1 | is_u2 | is_j;
        e.is_jal = is_j; e.is_jalr = is_jr; e.is_lui = is_u1; e.is_auipc = is_u2;
        e.mem_r_en = is_ld; e.mem_w_en = is_st; e.rd_is_mem = is_ld;
        if (is_ld || is_st) begin
            case (f3 % 4)
                0: e.mem_mask = 4'b0001;
                1: e.mem_mask = 4'b0011;
                2: e.mem_mask = 4'b1111;
                default: e.mem_mask = 4'b0000;
            endcase
        end
        return e;
    endfunction

    function automatic exp_t observed();
        exp_t o;
        o = {inst_type, imm, opcode, funct3, funct7, src1, src2, alu_result, pc_imm,
             gpr_w_en, pc_en, mem_if_en, is_branch, is_jal, is_jalr, mem_r_en, mem_w_en,
             mem_mask, rd_is_mem, is_lui, is_auipc};
        return o;
    endfunction

    function automatic exp_t model_now();
        return model(inst, pc, mregs[inst[19:15]], mregs[inst[24:20]]);
    endfunction

    // Commit the current instruction at the next posedge, then apply a new one mid-cycle.
    task automatic drive(input logic [31:0] i, input logic [31:0] p, input logic [31:0] s);
        exp_t e;
        @(posedge clk);
        e = model_now();
        if (rst && e.gpr_w_en && inst[11:7] != 5'd0) mregs[inst[11:7]] = srd;
        @(negedge clk);
        inst = i; pc = p; srd = s;
        #1;
    endtask

    function automatic logic [31:0] enc_i(input logic [11:0] im, input logic [4:0] r1, input logic [2:0] f3, input logic [4:0] rd, input logic [6:0] op);
        return {im, r1, f3, rd, op};
    endfunction

    function automatic logic [31:0] enc_s(input logic [11:0] im, input logic [4:0] r2, input logic [4:0] r1, input logic [2:0] f3);
        return {im[11:5], r2, r1, f3, im[4:0], 7'h23};
    endfunction

    function automatic logic [31:0] enc_b(input logic [12:0] im, input logic [4:0] r2, input logic [4:0] r1, input logic [2:0] f3);
        return {im[12], im[10:5], r2, r1, f3, im[4:1], im[11], 7'h63};
    endfunction

    function automatic logic [31:0] enc_j(input logic [20:0] im, input logic [4:0] rd);
        return {im[20], im[10:1], im[11], im[19:12], rd, 7'h6F};
    endfunction

    task automatic test_reset();
        inst = enc_i(12'h0, 5'd0, 3'd0, 5'd5, 7'h13);
        srd = 32'hDEADBEEF;
        repeat (2) @(posedge clk);
        @(negedge clk); #1;
        n_cmp++; if (pc_en !== 1'b0) begin n_err++; $display("FAIL reset_pc_en: got %b want 0", pc_en); end
        n_cmp++; if (mem_if_en !== 1'b0) begin n_err++; $display("FAIL reset_mem_if_en: got %b want 0", mem_if_en); end
        @(negedge clk);
        rst = 1'b1;
        inst = enc_i(12'h0, 5'd5, 3'd0, 5'd0, 7'h13);
        srd = 32'h0;
        #1;
        n_cmp++; if (src1 !== 32'h0) begin n_err++; $display("FAIL reset_x5: got %h want 00000000", src1); end
        n_cmp++; if (pc_en !== 1'b1) begin n_err++; $display("FAIL release_pc_en: got %b want 1", pc_en); end
        n_cmp++; if (mem_if_en !== 1'b1) begin n_err++; $display("FAIL release_mem_if_en: got %b want 1", mem_if_en); end
    endtask

    task automatic test_addi_shifts();
        drive(32'hFFF00093, 32'h0, 32'hFFFFFFFF);
        n_cmp++; if (imm !== 32'hFFFFFFFF) begin n_err++; $display("FAIL addi_imm: got %h want ffffffff", imm); end
        n_cmp++; if (alu_result !== 32'hFFFFFFFF) begin n_err++; $display("FAIL addi_alu: got %h want ffffffff", alu_result); end
        n_cmp++; if (gpr_w_en !== 1'b1) begin n_err++; $display("FAIL addi_wen: got %b want 1", gpr_w_en); end
        drive(enc_i(12'h404, 5'd1, 3'd5, 5'd2, 7'h13), 32'h4, 32'hFFFFFFFF);
        n_cmp++; if (alu_result !== 32'hFFFFFFFF) begin n_err++; $display("FAIL srai_alu: got %h want ffffffff", alu_result); end
        drive(enc_i(12'h004, 5'd1, 3'd5, 5'd2, 7'h13), 32'h8, 32'h0FFFFFFF);
        n_cmp++; if (alu_result !== 32'h0FFFFFFF) begin n_err++; $display("FAIL srli_alu: got %h want 0fffffff", alu_result); end
    endtask

    task automatic test_x0_write();
        drive(enc_i(12'd5, 5'd0, 3'd0, 5'd0, 7'h13), 32'h0, 32'd5);
        drive(enc_i(12'd0, 5'd0, 3'd0, 5'd3, 7'h13), 32'h0, 32'd0);
        n_cmp++; if (src1 !== 32'h0) begin n_err++; $display("FAIL x0_src1: got %h want 00000000", src1); end
        n_cmp++; if (alu_result !== 32'h0) begin n_err++; $display("FAIL x0_alu: got %h want 00000000", alu_result); end
    endtask

    task automatic test_branch();
        drive(enc_i(12'd1, 5'd0, 3'd0, 5'd2, 7'h13), 32'h0, 32'd1);
        drive(enc_b(13'd8, 5'd2, 5'd1, 3'd4), 32'h80000000, 32'h0);
        n_cmp++; if (alu_result !== 32'd1) begin n_err++; $display("FAIL blt_alu: got %h want 00000001", alu_result); end
        n_cmp++; if (is_branch !== 1'b1) begin n_err++; $display("FAIL blt_taken: got %b want 1", is_branch); end
        n_cmp++; if (pc_imm !== 32'h80000008) begin n_err++; $display("FAIL blt_target: got %h want 80000008", pc_imm); end
        n_cmp++; if (gpr_w_en !== 1'b0) begin n_err++; $display("FAIL blt_wen: got %b want 0", gpr_w_en); end
        drive(enc_b(13'd8, 5'd2, 5'd1, 3'd6), 32'h80000000, 32'h0);
        n_cmp++; if (is_branch !== 1'b0) begin n_err++; $display("FAIL bltu_taken: got %b want 0", is_branch); end
        drive(enc_b(13'd8, 5'd2, 5'd1, 3'd2), 32'h80000000, 32'h0);
        n_cmp++; if (is_branch !== 1'b0) begin n_err++; $display("FAIL b010_taken: got %b want 0", is_branch); end
    endtask

    task automatic test_mem();
        drive(enc_i(12'h100, 5'd0, 3'd0, 5'd1, 7'h13), 32'h0, 32'h100);
        drive(enc_s(12'hFFC, 5'd2, 5'd1, 3'd2), 32'h0, 32'h0);
        n_cmp++; if (mem_w_en !== 1'b1) begin n_err++; $display("FAIL sw_wen: got %b want 1", mem_w_en); end
        n_cmp++; if (mem_mask !== 4'b1111) begin n_err++; $display("FAIL sw_mask: got %b want 1111", mem_mask); end
        n_cmp++; if (alu_result !== 32'hFC) begin n_err++; $display("FAIL sw_addr: got %h want 000000fc", alu_result); end
        n_cmp++; if (gpr_w_en !== 1'b0) begin n_err++; $display("FAIL sw_gpr_wen: got %b want 0", gpr_w_en); end
        n_cmp++; if (src2 !== 32'd1) begin n_err++; $display("FAIL sw_data: got %h want 00000001", src2); end
        drive(enc_i(12'h0, 5'd1, 3'd1, 5'd4, 7'h03), 32'h0, 32'h1234);
        n_cmp++; if (mem_r_en !== 1'b1) begin n_err++; $display("FAIL lh_ren: got %b want 1", mem_r_en); end
        n_cmp++; if (mem_mask !== 4'b0011) begin n_err++; $display("FAIL lh_mask: got %b want 0011", mem_mask); end
        n_cmp++; if (rd_is_mem !== 1'b1) begin n_err++; $display("FAIL lh_rd_is_mem: got %b want 1", rd_is_mem); end
        n_cmp++; if (alu_result !== 32'h100) begin n_err++; $display("FAIL lh_addr: got %h want 00000100", alu_result); end
    endtask

    task automatic test_lui_jal_invalid();
        drive({20'h12345, 5'd3, 7'h37}, 32'h0, 32'h12345000);
        n_cmp++; if (imm !== 32'h12345000) begin n_err++; $display("FAIL lui_imm: got %h want 12345000", imm); end
        n_cmp++; if (is_lui !== 1'b1) begin n_err++; $display("FAIL lui_flag: got %b want 1", is_lui); end
        n_cmp++; if (inst_type !== 3'd4) begin n_err++; $display("FAIL lui_type: got %0d want 4", inst_type); end
        drive(enc_j(21'h1FFFF0, 5'd1), 32'h100, 32'h104);
        n_cmp++; if (pc_imm !== 32'hF0) begin n_err++; $display("FAIL jal_target: got %h want 000000f0", pc_imm); end
        n_cmp++; if (is_jal !== 1'b1) begin n_err++; $display("FAIL jal_flag: got %b want 1", is_jal); end
        n_cmp++; if (inst_type !== 3'd5) begin n_err++; $display("FAIL jal_type: got %0d want 5", inst_type); end
        drive(32'h0, 32'h200, 32'hFFFFFFFF);
        n_cmp++; if (inst_type !== 3'd7) begin n_err++; $display("FAIL inv_type: got %0d want 7", inst_type); end
        n_cmp++; if (imm !== 32'h0) begin n_err++; $display("FAIL inv_imm: got %h want 00000000", imm); end
        n_cmp++;
        if ({gpr_w_en, is_branch, is_jal, is_jalr, mem_r_en, mem_w_en, rd_is_mem, is_lui, is_auipc, mem_mask} !== 13'b0) begin
            n_err++;
            $display("FAIL inv_enables: got %b want all zero",
                     {gpr_w_en, is_branch, is_jal, is_jalr, mem_r_en, mem_w_en, rd_is_mem, is_lui, is_auipc, mem_mask});
        end
        n_cmp++; if ({pc_en, mem_if_en} !== 2'b11) begin n_err++; $display("FAIL inv_pc_en: got %b want 11", {pc_en, mem_if_en}); end
    endtask

    task automatic test_random(input int n);
        logic [6:0] ops [9] = '{7'h33, 7'h13, 7'h03, 7'h67, 7'h23, 7'h63, 7'h37, 7'h17, 7'h6F};
        logic [31:0] r;
        logic [6:0] op;
        exp_t e, o;
        for (int k = 0; k < n; k++) begin
            r = $urandom();
            op = ($urandom_range(0, 9) == 9) ? 7'($urandom()) : ops[$urandom_range(0, 8)];
            drive({r[31:7], op}, $urandom(), $urandom());
            e = model_now();
            o = observed();
            n_cmp++;
            if (o !== e) begin
                n_err++;
                $display("FAIL random[%0d] inst=%h: got %h want %h", k, inst, o, e);
            end
        end
    endtask

    initial begin
        for (int i = 0; i < 32; i++) mregs[i] = '0;
        test_reset();
        test_addi_shifts();
        test_x0_write();
        test_branch();
        test_mem();
        test_lui_jal_invalid();
        test_random(500);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
